// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : disp_arbiter
// Description: Round-robin arbiter that issues one display job at a time to a
//              display controller, with per-requester pending slots, overflow
//              tracking and a per-job timeout.
// Revision   : 1.0
// ============================================================================
module disp_arbiter #(
   parameter logic [26:0] TIMEOUT_MAX = 27'd12_500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [15:0] val0,
   input  logic [15:0] val1,
   input  logic [15:0] val2,
   input  logic [15:0] val3,
   input  logic [5:0]  fsm_state,
   input  logic        clr_ovf,
   output logic        set,
   output logic        start,
   output logic [15:0] input_value,
   output logic [1:0]  mode,
   output logic [3:0]  grant,
   output logic        done,
   output logic        timeout,
   output logic        busy,
   output logic [3:0]  ovf
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   localparam logic [5:0] FSM_DISPLAY = 6'b000010;
   localparam logic [5:0] FSM_FINISH  = 6'b001000;

   logic [1:0]  state_q, state_d;
   logic [26:0] cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        tmo_q, tmo_d;
   logic        busy_q;
   logic [1:0]  ptr_q;
   logic [1:0]  mode_q;
   logic [15:0] value_q;
   logic [3:0]  ovf_q;

   logic [15:0] w_val  [4];
   logic [15:0] w_slot [4];
   logic [3:0]  w_pend;
   logic [3:0]  w_ovf_set;
   logic        w_found;
   logic [1:0]  w_win;
   logic        w_take;
   logic [26:0] w_cnt_inc;
   logic        w_expire;
   logic        w_disp;
   logic        w_fin;

   assign w_val[0] = val0;
   assign w_val[1] = val1;
   assign w_val[2] = val2;
   assign w_val[3] = val3;

   // A grant clears the slot's pending bit, but a request in the same cycle
   // re-arms it with the new value; only a request onto a still-pending slot
   // counts as an overflow.
   for (genvar i = 0; i < 4; i++) begin : g_req
      logic        pend_q;
      logic [15:0] slot_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            pend_q <= 1'b0;
            slot_q <= 16'd0;
         end else if (req[i]) begin
            pend_q <= 1'b1;
            slot_q <= w_val[i];
         end else if (grant[i]) begin
            pend_q <= 1'b0;
         end
      end

      assign w_pend[i]    = pend_q;
      assign w_slot[i]    = slot_q;
      assign w_ovf_set[i] = req[i] && pend_q && !grant[i];
   end

   // Round-robin search begins one past the most recently released index.
   always_comb begin
      w_found = 1'b0;
      w_win   = ptr_q;
      for (int k = 1; k <= 4; k++) begin
         if (!w_found && w_pend[ptr_q + 2'(k)]) begin
            w_found = 1'b1;
            w_win   = ptr_q + 2'(k);
         end
      end
   end

   assign w_take    = (state_q == S_IDLE) && w_found && !rst;
   assign w_disp    = (fsm_state == FSM_DISPLAY);
   assign w_fin     = (fsm_state == FSM_FINISH);
   assign w_cnt_inc = cnt_q + 27'd1;
   assign w_expire  = (w_cnt_inc >= TIMEOUT_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_take) begin
               state_d = S_ISSUE;
               cnt_d   = 27'd0;
            end
         end
         S_ISSUE: begin
            cnt_d = w_cnt_inc;
            if (w_expire) begin
               state_d = S_RELEASE;
               tmo_d   = 1'b1;
            end else if (w_disp) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = w_cnt_inc;
            // A finish arriving on the expiry cycle still completes normally.
            if (w_fin) begin
               state_d = S_RELEASE;
               done_d  = 1'b1;
            end else if (w_expire) begin
               state_d = S_RELEASE;
               tmo_d   = 1'b1;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 27'd0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
         busy_q  <= 1'b0;
         ptr_q   <= 2'd3;
         mode_q  <= 2'd0;
         value_q <= 16'd0;
         ovf_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
         ovf_q   <= (clr_ovf ? 4'd0 : ovf_q) | w_ovf_set;
         if (w_take) begin
            mode_q  <= w_win;
            value_q <= w_slot[w_win];
            busy_q  <= 1'b1;
         end
         if (state_q == S_RELEASE) begin
            ptr_q  <= mode_q;
            busy_q <= 1'b0;
         end
      end
   end

   assign grant       = w_take ? (4'b0001 << w_win) : 4'b0000;
   assign set         = (state_q == S_ISSUE) && !w_disp && !rst;
   assign start       = set;
   assign mode        = mode_q;
   assign input_value = value_q;
   assign done        = done_q;
   assign timeout     = tmo_q;
   assign busy        = busy_q;
   assign ovf         = ovf_q;

endmodule
`default_nettype wire
